// File: rtl/slow_clock_monitor.sv
// ----------------------------------------------------------------------------
// slow_clock_monitor
//
// Receives the divided slow clock in the fast inp_clk domain. The slow clock
// is synchronized, turned into single-cycle rise/fall strobes (to be used as
// clock enables downstream), and the gap between successive edges is measured
// to qualify the divider output and track lock/stall state.
//
// Ports:
//   inp_clk      in   fast system clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   slow_clk     in   divided clock, asynchronous to inp_clk
//   rise_pulse   out  one-cycle strobe per synchronized rising edge
//   fall_pulse   out  one-cycle strobe per synchronized falling edge
//   half_period  out  last qualified half-period measurement (inp_clk cycles)
//   period_valid out  one-cycle strobe when half_period updates
//   locked       out  high while in LOCKED
//   stall        out  high while in STALLED
//   err_count    out  saturating count of lock losses from bad half-periods
// ----------------------------------------------------------------------------
module slow_clock_monitor #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned EXPECTED_HALF = 41,
   parameter int unsigned TOLERANCE     = 2,
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned TIMEOUT       = 164
) (
   input  logic             inp_clk,
   input  logic             rst_n,
   input  logic             slow_clk,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] half_period,
   output logic             period_valid,
   output logic             locked,
   output logic             stall,
   output logic [7:0]       err_count
);

   // state   | meaning
   // --------+-----------------------------------------------------------
   // IDLE    | no edge seen since reset; nothing measured, never times out
   // ACQUIRE | measuring, counting consecutive in-tolerance half-periods
   // LOCKED  | LOCK_COUNT good half-periods seen; monitoring for errors
   // STALLED | no edge for TIMEOUT cycles; next edge only restarts timing
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      STALLED = 2'd3
   } state_t;

   localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0]  EXP_C     = CNT_W'(EXPECTED_HALF);
   localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOLERANCE);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CNT_W-1:0]       cnt;
   logic [GOOD_W-1:0]      good;

   logic                   s_q;
   logic                   edge_det;
   logic [CNT_W-1:0]       diff;
   logic                   in_tol;
   logic                   timeout_hit;

   assign s_q      = sync_q[SYNC_STAGES-1];
   assign edge_det = s_q ^ prev_q;

   // Absolute deviation computed by ordering the operands so the
   // subtraction can never wrap.
   always_comb begin
      diff = '0;
      if (cnt >= EXP_C) diff = cnt - EXP_C;
      else              diff = EXP_C - cnt;
   end

   assign in_tol      = (diff <= TOL_C);
   assign timeout_hit = (cnt == TIMEOUT_C) && !edge_det;

   always_ff @(posedge inp_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '0;
         prev_q       <= 1'b0;
         cnt          <= '0;
         good         <= '0;
         state        <= IDLE;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         half_period  <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         stall        <= 1'b0;
         err_count    <= '0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], slow_clk};
         prev_q       <= s_q;
         rise_pulse   <= edge_det &  s_q;
         fall_pulse   <= edge_det & ~s_q;
         period_valid <= 1'b0;

         if (edge_det)          cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
         else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

         // locked/stall are written alongside every state change so they
         // always mirror the state register in the same cycle.
         case (state)
            IDLE: begin
               if (edge_det) begin
                  state <= ACQUIRE;
                  good  <= '0;
               end
            end
            ACQUIRE: begin
               if (edge_det) begin
                  half_period  <= cnt;
                  period_valid <= 1'b1;
                  if (in_tol) begin
                     if (good == GOOD_LAST) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        good   <= '0;
                     end else begin
                        good <= good + 1'b1;
                     end
                  end else begin
                     good <= '0;
                  end
               end else if (timeout_hit) begin
                  state <= STALLED;
                  stall <= 1'b1;
                  good  <= '0;
               end
            end
            LOCKED: begin
               if (edge_det) begin
                  half_period  <= cnt;
                  period_valid <= 1'b1;
                  if (!in_tol) begin
                     state  <= ACQUIRE;
                     locked <= 1'b0;
                     good   <= '0;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end else if (timeout_hit) begin
                  state  <= STALLED;
                  locked <= 1'b0;
                  stall  <= 1'b1;
                  good   <= '0;
               end
            end
            STALLED: begin
               // The edge ending a stall has no valid reference, so it only
               // restarts timing.
               if (edge_det) begin
                  state <= ACQUIRE;
                  stall <= 1'b0;
                  good  <= '0;
               end
            end
            default: begin
               state  <= IDLE;
               locked <= 1'b0;
               stall  <= 1'b0;
               good   <= '0;
            end
         endcase
      end
   end

endmodule
